// File: rtl/tt_trng_collector.sv
// Entropy collector: a run-length health test, optional von Neumann debiasing and LFSR whitening,
// then word packing into a DEPTH-entry valid/ready FIFO.
module tt_trng_collector #(
    parameter int                 WORD_W    = 8,
    parameter int                 DEPTH     = 4,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400,
    parameter int                 REP_LIMIT = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              raw_bit,
    input  logic              vn_en,
    input  logic              whiten_en,
    input  logic              health_clr,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              health_fail,
    output logic [7:0]        drop_cnt
);

    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CNT_W   = PTR_W + 1;
    localparam int             BC_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
    localparam logic [7:0]     REP_MAX = 8'(REP_LIMIT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    logic                raw_p0;
    logic                vld_p0;
    logic                prev_p1;
    logic [7:0]          rep_cnt;
    logic [7:0]          rep_next;
    logic                fail_now;
    logic                proc_p1;
    logic                vn_phase;
    logic                vn_first;
    logic                vn_en_q;
    logic                vn_phase_eff;
    logic                cand_v;
    logic                cand;
    logic                acc_bit;
    logic                accept;
    logic                word_done;
    logic [LFSR_W-1:0]   lfsr;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W-1:0]   acc_next;
    logic [BC_W-1:0]     bit_cnt;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                pop;
    logic                do_push;

    // Stage 0: capture the raw bit
    always_ff @(posedge clk) begin
        if (en) raw_p0 <= raw_bit;
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= en;
    end

    // Stage 1: health test, debias, whiten, pack
    always_comb begin
        rep_next     = (rep_cnt == 8'd0 || raw_p0 == prev_p1) ? sat_inc8(rep_cnt, REP_MAX) : 8'd1;
        fail_now     = vld_p0 && (rep_next == REP_MAX);
        proc_p1      = vld_p0 && !health_fail && !fail_now;
        vn_phase_eff = (vn_en != vn_en_q) ? 1'b0 : vn_phase;
        cand_v       = 1'b0;
        cand         = 1'b0;
        if (!vn_en) begin
            cand_v = 1'b1;
            cand   = raw_p0;
        end else if (vn_phase_eff) begin
            cand_v = (vn_first != raw_p0);
            cand   = vn_first;
        end
        accept    = proc_p1 && cand_v;
        acc_bit   = cand ^ (whiten_en & lfsr[LFSR_W-1]);
        acc_next  = {acc[WORD_W-2:0], acc_bit};
        word_done = accept && (bit_cnt == BC_LAST);
        full      = (count == CNT_W'(DEPTH));
        pop       = out_valid && out_ready;
        do_push   = word_done && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (vld_p0) prev_p1 <= raw_p0;
        if (proc_p1 && vn_en && !vn_phase_eff) vn_first <= raw_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt     <= 8'd0;
            health_fail <= 1'b0;
        end else if (fail_now) begin
            rep_cnt     <= rep_next;
            health_fail <= 1'b1;
        end else if (health_clr) begin
            rep_cnt     <= 8'd0;
            health_fail <= 1'b0;
        end else if (vld_p0) begin
            rep_cnt     <= rep_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vn_phase <= 1'b0;
            vn_en_q  <= 1'b0;
        end else if (fail_now) begin
            vn_phase <= 1'b0;
        end else if (proc_p1) begin
            vn_en_q  <= vn_en;
            vn_phase <= vn_en ? !vn_phase_eff : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= LFSR_W'(1);
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            if (accept) lfsr <= lfsr_step(lfsr);
            if (fail_now) begin
                acc     <= '0;
                bit_cnt <= '0;
            end else if (accept) begin
                acc     <= acc_next;
                bit_cnt <= word_done ? '0 : bit_cnt + BC_W'(1);
            end
        end
    end

    // Stage 2: output FIFO; a health failure flushes it
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= 8'd0;
        end else if (fail_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (word_done && full && !pop) drop_cnt <= sat_inc8(drop_cnt, 8'd255);
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_tt_trng_collector.sv
// Scoreboard bench for tt_trng_collector: a bit-list reference model predicts words, drops and
// health state; a negedge monitor pops expected words on each output handshake.
module tb_tt_trng_collector;

    localparam int         WORD_W = 8;
    localparam int         DEPTH  = 4;
    localparam int         LIMIT  = 31;
    localparam logic [15:0] TAPS  = 16'hB400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       raw_bit = 1'b0;
    logic       vn_en = 1'b0;
    logic       whiten_en = 1'b0;
    logic       health_clr = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       health_fail;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tt_trng_collector #(
        .WORD_W(WORD_W), .DEPTH(DEPTH), .LFSR_W(16), .LFSR_TAPS(TAPS), .REP_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .raw_bit(raw_bit), .vn_en(vn_en),
        .whiten_en(whiten_en), .health_clr(health_clr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .health_fail(health_fail),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: one call per rising edge using the inputs presented before it
    logic [7:0]  exp_q[$];
    bit          m_bits[$];
    bit          started = 0;
    bit          m_vld, m_raw, m_prev, m_fail, m_phase, m_first, m_vnq;
    int          m_rep, m_drop;
    logic [15:0] m_lfsr;

    always @(posedge clk) begin
        int  nrep;
        bit  failnow, has, c, b;
        logic [7:0] w;
        started = 1;
        if (rst) begin
            m_vld = 0; m_rep = 0; m_fail = 0; m_phase = 0; m_vnq = 0;
            m_lfsr = 16'd1; m_drop = 0;
            m_bits.delete();
            exp_q.delete();
        end else begin
            failnow = 0;
            if (m_vld) begin
                if (m_rep == 0 || m_raw == m_prev) nrep = (m_rep + 1 > LIMIT) ? LIMIT : m_rep + 1;
                else nrep = 1;
                m_prev = m_raw;
                if (nrep == LIMIT) begin
                    failnow = 1;
                    m_rep = nrep; m_fail = 1; m_phase = 0;
                    m_bits.delete();
                    exp_q.delete();
                end else begin
                    m_rep = nrep;
                    if (!m_fail) begin
                        if (vn_en != m_vnq) m_phase = 0;
                        m_vnq = vn_en;
                        has = 0; c = 0;
                        if (!vn_en) begin
                            has = 1; c = m_raw; m_phase = 0;
                        end else if (!m_phase) begin
                            m_first = m_raw; m_phase = 1;
                        end else begin
                            m_phase = 0;
                            if (m_first != m_raw) begin has = 1; c = m_first; end
                        end
                        if (has) begin
                            b = c ^ (whiten_en & m_lfsr[15]);
                            m_lfsr = {m_lfsr[14:0], ^(m_lfsr & TAPS)};
                            m_bits.push_back(b);
                            if (m_bits.size() == WORD_W) begin
                                w = 8'd0;
                                foreach (m_bits[k]) w = {w[6:0], m_bits[k]};
                                m_bits.delete();
                                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                                else if (m_drop < 255) m_drop++;
                            end
                        end
                    end
                end
            end
            if (!failnow && health_clr) begin m_fail = 0; m_rep = 0; end
            if (en) m_raw = raw_bit;
            m_vld = en;
        end
    end

    // Monitor: handshakes are decided by the inputs presented for the coming edge
    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("health_fail", 32'(health_fail), 32'(m_fail));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (!out_valid) chk("idle_data", 32'(out_data), 32'd0);
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL word actual=%0h required=none", out_data);
                end else begin
                    chk("word", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        logic [19:0] vnpat;
        int hold;
        vnpat = 20'b10010011100110100101;

        // Reset with random inputs
        rst = 1;
        en = 1'($urandom); raw_bit = 1'($urandom); vn_en = 1'($urandom);
        whiten_en = 1'($urandom); health_clr = 1'($urandom); out_ready = 1'($urandom);
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_health", 32'(health_fail), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        step(); step();

        // Plain packing
        rst = 0; en = 1; vn_en = 0; whiten_en = 0; health_clr = 0; out_ready = 1;
        for (int i = 0; i < 8; i++) begin raw_bit = 1'(i & 1); step(); end
        chk("plain_lat_early", 32'(out_valid), 32'd0);
        raw_bit = 0; step();
        chk("plain_lat_valid", 32'(out_valid), 32'd1);
        chk("plain_word0", 32'(out_data), 32'h55);
        for (int i = 9; i < 25; i++) begin raw_bit = 1'(i & 1); step(); end
        en = 0; repeat (3) step();

        // Whitening
        do_reset();
        whiten_en = 1; out_ready = 0; en = 1;
        for (int i = 0; i < 16; i++) begin raw_bit = 1'(i & 1); step(); end
        en = 0; step();
        chk("white_word0", 32'(out_data), 32'h55);
        out_ready = 1; step();
        chk("white_word1", 32'(out_data), 32'h54);
        step(); step();
        whiten_en = 0;

        // Von Neumann
        do_reset();
        vn_en = 1; out_ready = 0; en = 1;
        for (int i = 19; i >= 0; i--) begin raw_bit = vnpat[i]; step(); end
        en = 0; step();
        chk("vn_valid", 32'(out_valid), 32'd1);
        chk("vn_word", 32'(out_data), 32'hAC);
        out_ready = 1; step(); step();
        vn_en = 0;

        // Overflow, then push against a full FIFO with a simultaneous pop
        do_reset();
        out_ready = 0; en = 1;
        for (int i = 0; i < 48; i++) begin raw_bit = 1'($urandom); step(); end
        en = 0; step();
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        en = 1;
        for (int i = 0; i < 8; i++) begin raw_bit = 1'($urandom); step(); end
        en = 0; out_ready = 1; step();
        out_ready = 0;
        chk("full_pushpop_drop", 32'(drop_cnt), 32'd2);
        out_ready = 1; repeat (6) step();
        chk("ovf_drained", 32'(out_valid), 32'd0);

        // Health failure and recovery
        do_reset();
        out_ready = 0; en = 1;
        for (int i = 0; i < 16; i++) begin raw_bit = ~1'(i & 1); step(); end
        chk("hlth_buffered", 32'(out_valid), 32'd1);
        raw_bit = 1;
        repeat (31) step();
        chk("hlth_pre", 32'(health_fail), 32'd0);
        step();
        chk("hlth_fail", 32'(health_fail), 32'd1);
        chk("hlth_flush", 32'(out_valid), 32'd0);
        repeat (4) step();
        chk("hlth_nopush", 32'(out_valid), 32'd0);
        raw_bit = 0; step();
        raw_bit = 1; health_clr = 1; step();
        health_clr = 0;
        chk("hlth_clr", 32'(health_fail), 32'd0);
        for (int i = 1; i < 8; i++) begin raw_bit = ~1'(i & 1); step(); end
        en = 0; step();
        chk("hlth_resume", 32'(out_data), 32'hAA);
        out_ready = 1; step(); step();

        // Randomized traffic
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = ($urandom_range(0, 699) == 0);
            en         = ($urandom_range(0, 9) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            health_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) vn_en = ~vn_en;
            if ($urandom_range(0, 49) == 0) whiten_en = ~whiten_en;
            if (hold > 0) hold--;
            else if ($urandom_range(0, 199) == 0) hold = 40;
            else raw_bit = 1'($urandom);
            step();
        end

        // Drain
        rst = 0; en = 0; health_clr = 0; out_ready = 1;
        repeat (20) step();
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
